// File: rtl/opti_sos_tdm.sv
// Time-multiplexed Direct-Form-I biquad shared by NCH channels, one multiplier, five products per sample.
// Build option: define OPTI_SOS_SAT_EN to clamp the rounded result instead of wrapping it to DW bits.
module opti_sos_tdm #(
  parameter int DW   = 24,
  parameter int FRAC = 22,
  parameter int NCH  = 4,
  parameter int CHW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic signed [DW-1:0]  i_b0,
  input  logic signed [DW-1:0]  i_b1,
  input  logic signed [DW-1:0]  i_b2,
  input  logic signed [DW-1:0]  i_a1,
  input  logic signed [DW-1:0]  i_a2,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [CHW-1:0]        i_in_ch,
  input  logic signed [DW-1:0]  i_in_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [CHW-1:0]        o_out_ch,
  output logic signed [DW-1:0]  o_out_data,
  output logic                  o_err_ch
);

  localparam int ACCW = 2*DW + 3;
  localparam int IW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic signed [ACCW-1:0] RND  = ACCW'(1) << (FRAC-1);
  localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SMIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_OUT} state_t;

  state_t                  r_state;
  state_t                  w_nextState;
  logic                    r_live;
  logic [CHW-1:0]          r_ch;
  logic signed [DW-1:0]    r_x;
  logic signed [ACCW-1:0]  r_acc;
  logic [CHW-1:0]          r_outCh;
  logic signed [DW-1:0]    r_outData;
  logic                    r_err;
  logic signed [DW-1:0]    r_x1 [0:NCH-1];
  logic signed [DW-1:0]    r_x2 [0:NCH-1];
  logic signed [DW-1:0]    r_y1 [0:NCH-1];
  logic signed [DW-1:0]    r_y2 [0:NCH-1];

  logic [IW-1:0]           w_idx;
  logic                    w_accept;
  logic                    w_chOk;
  logic signed [DW-1:0]    w_mulA;
  logic signed [DW-1:0]    w_mulB;
  logic                    w_neg;
  logic signed [2*DW-1:0]  w_prod;
  logic signed [ACCW-1:0]  w_prodExt;
  logic signed [ACCW-1:0]  w_term;
  logic signed [ACCW-1:0]  w_accNext;
  logic signed [ACCW-1:0]  w_rnd;
  logic signed [ACCW-1:0]  w_shift;
  logic signed [DW-1:0]    w_red;

  assign w_idx      = r_ch[IW-1:0];
  assign w_accept   = i_in_valid & o_in_ready;
  assign w_chOk     = (int'(i_in_ch) < NCH);
  assign o_out_ch   = r_outCh;
  assign o_out_data = r_outData;
  assign o_err_ch   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    o_in_ready  = r_live && (r_state == S_IDLE);
    o_out_valid = (r_state == S_OUT);
    if (i_clr) begin
      w_nextState = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept && w_chOk) w_nextState = S_M0;
        S_M0:    w_nextState = S_M1;
        S_M1:    w_nextState = S_M2;
        S_M2:    w_nextState = S_M3;
        S_M3:    w_nextState = S_M4;
        S_M4:    w_nextState = S_OUT;
        S_OUT:   if (i_out_ready) w_nextState = S_IDLE;
        default: w_nextState = S_IDLE;
      endcase
    end
  end

  // Operand select for the single shared multiplier; feedback terms are subtracted.
  always_comb begin
    w_mulA = '0;
    w_mulB = '0;
    w_neg  = 1'b0;
    case (r_state)
      S_M0:    begin w_mulA = i_b0; w_mulB = r_x;         end
      S_M1:    begin w_mulA = i_b1; w_mulB = r_x1[w_idx]; end
      S_M2:    begin w_mulA = i_b2; w_mulB = r_x2[w_idx]; end
      S_M3:    begin w_mulA = i_a1; w_mulB = r_y1[w_idx]; w_neg = 1'b1; end
      S_M4:    begin w_mulA = i_a2; w_mulB = r_y2[w_idx]; w_neg = 1'b1; end
      default: begin w_mulA = '0;   w_mulB = '0;          end
    endcase
  end

  assign w_prod    = (2*DW)'(w_mulA) * (2*DW)'(w_mulB);
  assign w_prodExt = ACCW'(w_prod);
  assign w_term    = w_neg ? -w_prodExt : w_prodExt;
  assign w_accNext = (r_state == S_M0) ? w_term : (r_acc + w_term);
  assign w_rnd     = w_accNext + RND;
  assign w_shift   = w_rnd >>> FRAC;

  always_comb begin
    w_red = DW'(w_shift);
`ifdef OPTI_SOS_SAT_EN
    if (w_shift > SMAX)      w_red = DW'(SMAX);
    else if (w_shift < SMIN) w_red = DW'(SMIN);
`else
    if (w_shift > SMAX)      w_red = DW'(w_shift);
    else if (w_shift < SMIN) w_red = DW'(w_shift);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live    <= 1'b0;
      r_ch      <= '0;
      r_x       <= '0;
      r_acc     <= '0;
      r_outCh   <= '0;
      r_outData <= '0;
      r_err     <= 1'b0;
    end else begin
      r_live <= 1'b1;
      r_err  <= w_accept & ~w_chOk & ~i_clr;
      if (w_accept) begin
        r_ch <= i_in_ch;
        r_x  <= i_in_data;
      end
      if (r_state inside {S_M0, S_M1, S_M2, S_M3, S_M4}) r_acc <= w_accNext;
      if ((r_state == S_M4) && !i_clr) begin
        r_outData <= w_red;
        r_outCh   <= r_ch;
      end
    end
  end

  // History advances only when the output is actually taken; y history keeps the emitted value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_x1[i] <= '0;
        r_x2[i] <= '0;
        r_y1[i] <= '0;
        r_y2[i] <= '0;
      end
    end else if (i_clr) begin
      for (int i = 0; i < NCH; i++) begin
        r_x1[i] <= '0;
        r_x2[i] <= '0;
        r_y1[i] <= '0;
        r_y2[i] <= '0;
      end
    end else if ((r_state == S_OUT) && i_out_ready) begin
      r_x2[w_idx] <= r_x1[w_idx];
      r_x1[w_idx] <= r_x;
      r_y2[w_idx] <= r_y1[w_idx];
      r_y1[w_idx] <= r_outData;
    end
  end

endmodule

// File: tb/tb_opti_sos_tdm.sv
// Scoreboard bench for opti_sos_tdm: directed samples push expected outputs, a monitor pops on each handshake.
module tb_opti_sos_tdm;

  localparam int DW   = 24;
  localparam int FRAC = 22;
  localparam int NCH  = 4;
  localparam int CHW  = 3;
`ifdef OPTI_SOS_SAT_EN
  localparam logic [DW-1:0] SAT_EXP = 24'h7FFFFF;
`else
  localparam logic [DW-1:0] SAT_EXP = 24'h900000;
`endif

  logic           clk = 1'b0;
  logic           rstN;
  logic           clr;
  logic [DW-1:0]  b0, b1, b2, a1, a2;
  logic           inValid;
  logic           inReady;
  logic [CHW-1:0] inCh;
  logic [DW-1:0]  inData;
  logic           outValid;
  logic           outReady;
  logic [CHW-1:0] outCh;
  logic [DW-1:0]  outData;
  logic           errCh;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [DW-1:0]  data;
  } expT;
  expT expQ[$];
  expT monE;

  always #5 clk = ~clk;

  opti_sos_tdm #(.DW(DW), .FRAC(FRAC), .NCH(NCH), .CHW(CHW)) dut (
    .clk(clk), .rst_n(rstN), .i_clr(clr),
    .i_b0(b0), .i_b1(b1), .i_b2(b2), .i_a1(a1), .i_a2(a2),
    .i_in_valid(inValid), .o_in_ready(inReady), .i_in_ch(inCh), .i_in_data(inData),
    .o_out_valid(outValid), .i_out_ready(outReady), .o_out_ch(outCh), .o_out_data(outData),
    .o_err_ch(errCh)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: every output handshake is compared with the oldest expected result.
  always @(negedge clk) begin
    if (rstN && outValid && outReady) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got ch=%0d data=%h required none", outCh, outData);
      end else begin
        monE = expQ.pop_front();
        checkOutput("out_ch", 32'(outCh), 32'(monE.ch));
        checkOutput("out_data", 32'(outData), 32'(monE.data));
      end
    end
  end

  task automatic applyStimulus(input logic [CHW-1:0] ch, input logic [DW-1:0] x,
                               input bit expectOut, input logic [DW-1:0] expY);
    int n;
    if (expectOut) expQ.push_back('{ch: ch, data: expY});
    @(posedge clk);
    #1;
    inValid = 1'b1;
    inCh    = ch;
    inData  = x;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!inReady && n < 100);
    if (!inReady) begin
      checks++;
      errors++;
      $display("[TB] FAIL in_ready_timeout: got 0 required 1");
      inValid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      inValid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int k;
    k = 0;
    while ((expQ.size() != 0 || outValid) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending required 0", expQ.size());
    end
  endtask

  task automatic doClear();
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic setCoeffs(input logic [DW-1:0] c0, c1, c2, d1, d2);
    b0 = c0; b1 = c1; b2 = c2; a1 = d1; a2 = d2;
  endtask

  initial begin
    int k;
    int seen;
    rstN = 1'b0; clr = 1'b0; inValid = 1'b0; inCh = '0; inData = '0; outReady = 1'b1;
    setCoeffs(0, 0, 0, 0, 0);

    @(negedge clk);
    checkOutput("rst_in_ready", 32'(inReady), 0);
    checkOutput("rst_out_valid", 32'(outValid), 0);
    checkOutput("rst_out_ch", 32'(outCh), 0);
    checkOutput("rst_out_data", 32'(outData), 0);
    checkOutput("rst_err_ch", 32'(errCh), 0);
    #2 rstN = 1'b1;
    #1 checkOutput("rel_in_ready_before_edge", 32'(inReady), 0);
    @(negedge clk);
    checkOutput("rel_in_ready_after_edge", 32'(inReady), 1);

    // Pass-through gain of 1.0 and latency
    setCoeffs(24'h400000, 0, 0, 0, 0);
    applyStimulus(0, 24'h123456, 1, 24'h123456);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!outValid && k < 20);
    checkOutput("latency", 32'(k), 6);
    waitDrain();

    // One-pole decay, y = x + 0.5*y1
    doClear();
    setCoeffs(24'h400000, 0, 0, 24'hE00000, 0);
    applyStimulus(1, 24'h400000, 1, 24'h400000);
    applyStimulus(1, 24'h000000, 1, 24'h200000);
    applyStimulus(1, 24'h000000, 1, 24'h100000);
    waitDrain();

    // Interleaved channels decay independently
    doClear();
    applyStimulus(0, 24'h200000, 1, 24'h200000);
    applyStimulus(2, 24'h100000, 1, 24'h100000);
    applyStimulus(0, 24'h000000, 1, 24'h100000);
    applyStimulus(2, 24'h000000, 1, 24'h080000);
    applyStimulus(0, 24'h000000, 1, 24'h080000);
    applyStimulus(2, 24'h000000, 1, 24'h040000);
    applyStimulus(3, 24'h300000, 1, 24'h300000);
    waitDrain();

    // All five taps: y = x + .5x1 + .25x2 + .5y1 - .25y2
    doClear();
    setCoeffs(24'h400000, 24'h200000, 24'h100000, 24'hE00000, 24'h100000);
    applyStimulus(1, 24'h100000, 1, 24'h100000);
    applyStimulus(1, 24'h100000, 1, 24'h200000);
    applyStimulus(1, 24'h100000, 1, 24'h280000);
    applyStimulus(1, 24'h000000, 1, 24'h180000);
    waitDrain();

    // Rounding half up at the LSB
    doClear();
    setCoeffs(24'h000001, 0, 0, 0, 0);
    applyStimulus(0, 24'h200000, 1, 24'h000001);
    applyStimulus(0, 24'hE00000, 1, 24'h000000);
    applyStimulus(0, 24'h1FFFFF, 1, 24'h000000);
    waitDrain();

    // Output stall holds data and blocks input
    doClear();
    setCoeffs(24'h400000, 0, 0, 24'hE00000, 0);
    outReady = 1'b0;
    applyStimulus(0, 24'h100000, 1, 24'h100000);
    k = 0;
    while (!outValid && k < 20) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("stall_hold", {3'b0, outValid, inReady, outCh, outData},
                  {3'b0, 1'b1, 1'b0, 3'd0, 24'h100000});
    end
    @(posedge clk);
    #1 outReady = 1'b1;
    applyStimulus(0, 24'h000000, 1, 24'h080000);
    waitDrain();

    // Out-of-range channel: error pulse, no output, no history change
    applyStimulus(5, 24'h123456, 0, 24'h0);
    @(negedge clk);
    checkOutput("err_pulse", 32'(errCh), 1);
    checkOutput("err_in_ready", 32'(inReady), 1);
    @(negedge clk);
    checkOutput("err_pulse_end", 32'(errCh), 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (outValid) seen++;
    end
    checkOutput("err_no_output", 32'(seen), 0);
    applyStimulus(0, 24'h000000, 1, 24'h040000);
    waitDrain();

    // Overflow handling, then clear mid-computation
    doClear();
    setCoeffs(24'h600000, 0, 0, 24'hE00000, 0);
    applyStimulus(0, 24'h600000, 1, SAT_EXP);
    waitDrain();
    applyStimulus(0, 24'h600000, 0, 24'h0);
    @(posedge clk);
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (outValid) seen++;
    end
    checkOutput("clr_no_output", 32'(seen), 0);
    applyStimulus(0, 24'h100000, 1, 24'h180000);
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
